// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug controllers: run-state encoding
// and default sizing for the program counter and slow-run divider.
package cpu_dbg_pkg;

  localparam int DEF_PC_W     = 9;
  localparam int DEF_DIV_W    = 24;
  localparam int DEF_SLOW_DIV = 12500000;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SLOW = 2'd2,
    ST_BRK  = 2'd3
  } run_state_e;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw board button plus a registered
// rising-edge detector; a held button yields exactly one pulse.
module btn_edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  // Pulse appears 3 clk after the raw edge: two sync stages plus the edge register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step/breakpoint controller producing the core instruction enable.
// Build option: define CPU_RUN_CTRL_CNT_EN to include the executed-instruction counter.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int DIV_W    = DEF_DIV_W,
  parameter int SLOW_DIV = DEF_SLOW_DIV
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            run_req_i,
  input  logic            slow_mode_i,
  input  logic            step_btn_i,
  input  logic            bp_en_i,
  input  logic [PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            cpu_en_o,
  output logic            halted_o,
  output logic            bp_hit_o,
  output logic [1:0]      state_o,
  output logic [15:0]     instr_cnt_o
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

  run_state_e       state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             armed_q, armed_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_pulse;
  logic             bp_match;
  logic             brk_cut;
  logic             div_last;

  btn_edge_sync u_step_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (step_btn_i),
    .pulse_o (step_pulse)
  );

  assign div_last = (div_q == DIV_LAST);
  // Only an instruction actually being issued can hit the breakpoint.
  assign bp_match = bp_en_i && armed_q && cpu_en_q && (pc_i == bp_addr_i);
  assign brk_cut  = run_req_i && bp_match && ((state_q == ST_RUN) || (state_q == ST_SLOW));
  assign cpu_en_o = cpu_en_q && !brk_cut;

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    armed_d  = armed_q | cpu_en_o;
    div_d    = div_q;
    case (state_q)
      ST_HALT: begin
        if (run_req_i) begin
          state_d  = slow_mode_i ? ST_SLOW : ST_RUN;
          cpu_en_d = !slow_mode_i;
          armed_d  = 1'b0;
          div_d    = '0;
        end else if (step_pulse) begin
          cpu_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_req_i) begin
          state_d = ST_HALT;
        end else if (bp_match) begin
          state_d = ST_BRK;
        end else if (slow_mode_i) begin
          state_d = ST_SLOW;
          div_d   = '0;
        end else begin
          cpu_en_d = 1'b1;
        end
      end
      ST_SLOW: begin
        div_d = div_last ? '0 : div_q + DIV_W'(1);
        if (!run_req_i) begin
          state_d = ST_HALT;
        end else if (bp_match) begin
          state_d = ST_BRK;
        end else if (!slow_mode_i) begin
          state_d  = ST_RUN;
          cpu_en_d = 1'b1;
        end else begin
          cpu_en_d = div_last;
        end
      end
      ST_BRK: begin
        // Staying here while run_req is held forces a 0->1 toggle to resume.
        if (!run_req_i) begin
          state_d = ST_HALT;
        end else if (step_pulse) begin
          state_d  = ST_HALT;
          cpu_en_d = 1'b1;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_HALT;
      cpu_en_q <= 1'b0;
      armed_q  <= 1'b0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
      armed_q  <= armed_d;
      div_q    <= div_d;
    end
  end

  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALT) || (state_q == ST_BRK);
  assign bp_hit_o = (state_q == ST_BRK);

`ifdef CPU_RUN_CTRL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = cpu_en_o ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt_o = cnt_q;
`else
  assign instr_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a small PC-advancing core model.
module tb_cpu_run_ctrl;

  localparam int PC_W = 9;

  logic            clk;
  logic            reset, run_req, slow_mode, step_btn, bp_en;
  logic [PC_W-1:0] bp_addr, pc;
  logic            cpu_en, halted, bp_hit;
  logic [1:0]      state;
  logic [15:0]     instr_cnt;
  logic            en_s;

  int errors = 0;
  int checks = 0;

  cpu_run_ctrl #(.PC_W(PC_W), .DIV_W(8), .SLOW_DIV(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .run_req_i   (run_req),
    .slow_mode_i (slow_mode),
    .step_btn_i  (step_btn),
    .bp_en_i     (bp_en),
    .bp_addr_i   (bp_addr),
    .pc_i        (pc),
    .cpu_en_o    (cpu_en),
    .halted_o    (halted),
    .bp_hit_o    (bp_hit),
    .state_o     (state),
    .instr_cnt_o (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: PC advances after every edge that ended a cpu_en cycle.
  initial begin
    pc = '0;
    forever begin
      @(negedge clk);
      en_s = cpu_en;
      @(posedge clk);
      #1;
      if (reset) pc = '0;
      else if (en_s) pc = pc + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ec(input int n);
`ifdef CPU_RUN_CTRL_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1; run_req = 1'b0; slow_mode = 1'b0; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       rr;
    logic       sm;
    logic [1:0] st;
    logic       en;
    int         cnt;
  } vec_t;

  vec_t vt[19];

  initial begin
    int  hits;
    int  at;
    logic found;

    // inputs {run_req, slow_mode}; expected {state, cpu_en, instr_cnt} after the edge
    vt[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 0};
    vt[1]  = '{1'b1, 1'b1, 2'd2, 1'b0, 0};
    vt[2]  = '{1'b1, 1'b1, 2'd2, 1'b0, 0};
    vt[3]  = '{1'b1, 1'b1, 2'd2, 1'b0, 0};
    vt[4]  = '{1'b1, 1'b1, 2'd2, 1'b0, 0};
    vt[5]  = '{1'b1, 1'b1, 2'd2, 1'b1, 0};
    vt[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1};
    vt[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1};
    vt[8]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1};
    vt[9]  = '{1'b1, 1'b1, 2'd2, 1'b1, 1};
    vt[10] = '{1'b1, 1'b1, 2'd2, 1'b0, 2};
    vt[11] = '{1'b1, 1'b0, 2'd1, 1'b1, 2};
    vt[12] = '{1'b1, 1'b0, 2'd1, 1'b1, 3};
    vt[13] = '{1'b1, 1'b1, 2'd2, 1'b0, 4};
    vt[14] = '{1'b1, 1'b1, 2'd2, 1'b0, 4};
    vt[15] = '{1'b0, 1'b1, 2'd0, 1'b0, 4};
    vt[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 4};
    vt[17] = '{1'b1, 1'b0, 2'd1, 1'b1, 4};
    vt[18] = '{1'b0, 1'b0, 2'd0, 1'b0, 5};

    // Reset and idle HALT
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("idle_state", state, 0);
      chk("idle_en", cpu_en, 0);
      chk("idle_halted", halted, 1);
      chk("idle_cnt", instr_cnt, 0);
      tick();
    end

    // Single step from HALT: one pulse, 4 clk after the raw edge
    step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("step_en_timing", cpu_en, (k == 4) ? 1 : 0);
    end
    step_btn = 1'b0;
    repeat (4) tick();
    chk("step1_cnt", instr_cnt, ec(1));
    chk("step1_state", state, 0);
    step_btn = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (cpu_en) hits++;
    end
    step_btn = 1'b0;
    repeat (4) tick();
    chk("step2_pulses", hits, 1);
    chk("step2_cnt", instr_cnt, ec(2));

    // Table: slow run, slow->run, run->slow, halt
    do_reset();
    for (int i = 0; i < 19; i++) begin
      run_req   = vt[i].rr;
      slow_mode = vt[i].sm;
      tick();
      chk($sformatf("vec%0d_state", i), state, vt[i].st);
      chk($sformatf("vec%0d_en", i), cpu_en, vt[i].en);
      chk($sformatf("vec%0d_halted", i), halted, (vt[i].st == 2'd0 || vt[i].st == 2'd3) ? 1 : 0);
      chk($sformatf("vec%0d_bphit", i), bp_hit, (vt[i].st == 2'd3) ? 1 : 0);
      chk($sformatf("vec%0d_cnt", i), instr_cnt, ec(vt[i].cnt));
    end

    // Breakpoint at 5 from a fresh run
    do_reset();
    bp_en = 1'b1; bp_addr = 9'h005; run_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (state == 2'd3) found = 1'b1;
    end
    chk("brk1_reached", found, 1);
    chk("brk1_pc", pc, 5);
    chk("brk1_cnt", instr_cnt, ec(5));
    chk("brk1_bphit", bp_hit, 1);
    chk("brk1_halted", halted, 1);
    for (int i = 0; i < 3; i++) begin
      chk("brk1_en_off", cpu_en, 0);
      tick();
    end
    chk("brk1_pc_hold", pc, 5);

    // Resume via run_req 0 -> 1 executes past the breakpoint
    run_req = 1'b0;
    tick();
    chk("resume_halt", state, 0);
    run_req = 1'b1;
    tick();
    chk("resume_run", state, 1);
    tick();
    chk("resume_pc", pc, 6);
    chk("resume_state", state, 1);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (state == 2'd3) found = 1'b1;
    end
    chk("brk2_reached", found, 1);
    chk("brk2_pc", pc, 5);
    chk("brk2_cnt", instr_cnt, ec(517));

    // Step out of BRK while run_req still held
    step_btn = 1'b1;
    at = 0;
    for (int k = 1; k <= 8 && at == 0; k++) begin
      tick();
      if (cpu_en) at = k;
    end
    chk("brkstep_latency", at, 4);
    chk("brkstep_state", state, 0);
    run_req = 1'b0;
    tick();
    chk("brkstep_pc", pc, 6);
    chk("brkstep_en_once", cpu_en, 0);
    chk("brkstep_halt", state, 0);
    chk("brkstep_cnt", instr_cnt, ec(518));
    step_btn = 1'b0;

    // run_req rising with step_pulse: run wins; then reset mid-run
    do_reset();
    step_btn = 1'b1;
    repeat (3) tick();
    run_req = 1'b1;
    tick();
    chk("runwins_state", state, 1);
    chk("runwins_en", cpu_en, 1);
    repeat (3) tick();
    chk("runwins_cnt", instr_cnt, ec(3));
    chk("runwins_still_run", state, 1);
    reset = 1'b1;
    tick();
    chk("midreset_state", state, 0);
    chk("midreset_en", cpu_en, 0);
    chk("midreset_cnt", instr_cnt, 0);
    reset = 1'b0;
    step_btn = 1'b0;
    run_req = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt/single-step controller for the PIC10-compatible CPU core. It generates the core's instruction clock-enable from board switches and a push-button, and supports full-speed run, divided slow run, single step and one PC breakpoint. It sits between the board I/O and the core, alongside the register-watch display, so users can freeze the core and inspect registers.

Parameters:
PC_W, 9, program counter width
DIV_W, 24, slow-run divider counter width
SLOW_DIV, 12500000, clk cycles per instruction in slow mode (4 Hz at 50 MHz); legal range 2..2^DIV_W-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run_req  in  1  level switch; 1 requests free-running execution
slow_mode  in  1  1 selects divided run rate when running
step_btn  in  1  raw single-step push-button, active-high (asynchronous to clk)
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
pc  in  PC_W  current core PC (the instruction about to execute)
cpu_en  out  1  core instruction enable; each high cycle executes one instruction
halted  out  1  1 in HALT or BRK
bp_hit  out  1  1 in BRK
state  out  2  encoded state, for the LEDs
instr_cnt  out  16  executed-instruction counter

Behaviour:
- One clock; synchronous active-high reset. Reset values: state=HALT, cpu_en=0, halted=1, bp_hit=0, instr_cnt=0, divider=0, armed=0, synchronizer flops=0. Reset asserted mid-run takes effect on the next edge.
- step_btn: 2-flop synchronizer, then rising-edge detect, giving step_pulse (1 cycle). Latency from the raw edge to step_pulse is 3 clk. A held button gives one pulse only.
- State encoding: HALT=0, RUN=1, SLOW=2, BRK=3.
- cpu_en is registered. The pulse appears the cycle after its decision.
- HALT:
  - run_req=1 and slow_mode=0 -> RUN; run_req=1 and slow_mode=1 -> SLOW. Entering either state clears armed and divider.
  - Otherwise step_pulse -> a single cpu_en pulse, staying in HALT.
  - If run_req and step_pulse occur together, run wins and the step is discarded.
- RUN:
  - cpu_en=1 every cycle.
  - run_req=0 -> HALT.
  - slow_mode=1 -> SLOW, with divider cleared.
  - Breakpoint check: bp_en and armed and pc==bp_addr -> BRK. cpu_en is forced to 0 from that cycle, so the instruction at bp_addr is not executed.
- SLOW:
  - The divider counts 0..SLOW_DIV-1 and wraps.
  - cpu_en pulses one cycle when divider==SLOW_DIV-1.
  - Same exit and breakpoint rules as RUN; slow_mode=0 -> RUN.
  - Breakpoint checked on the pulse cycle only.
- armed is set on the first cpu_en pulse after entering RUN or SLOW. This lets a run resumed at bp_addr execute past it.
- BRK:
  - cpu_en=0.
  - step_pulse -> one cpu_en pulse, then HALT.
  - run_req=0 -> HALT.
  - run_req stays 1 -> remain in BRK. Resuming requires run_req 0 -> 1.
  - bp_en deassertion does not leave BRK.
- Priority per cycle: reset > run_req exit > breakpoint > step > mode change.
- instr_cnt increments on every cpu_en=1 cycle and wraps at 16'hFFFF -> 0.
- halted and bp_hit decode directly from the state register (no extra latency).

Optional Feature:
CPU_RUN_CTRL_CNT_EN
- Defined: the instr_cnt register exists as above.
- Undefined: the counter is removed and instr_cnt is tied to 16'h0000. All other behaviour is unchanged.

Decomposition:
- Shared package/header cpu_dbg_pkg holds the state encodings (ST_HALT, ST_RUN, ST_SLOW, ST_BRK), the default SLOW_DIV and PC_W.
- One sub-module, btn_edge_sync: 2-flop synchronizer plus rising-edge pulse, reused for other board buttons.
- The FSM, divider and counter stay in cpu_run_ctrl.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> state=0, cpu_en=0, halted=1, instr_cnt=0 held for 20 cycles.
- HALT, step_btn high for 10 cycles -> exactly one cpu_en pulse, 4 clk after the raw edge; instr_cnt=1; a second press gives instr_cnt=2.
- run_req=1, slow_mode=0, bp_en=1, bp_addr=9'h005, pc incrementing on each cpu_en from 0 -> cpu_en high for pc 0..4, state=BRK when pc=5, cpu_en=0 after, bp_hit=1, instr_cnt=5.
- From BRK at pc=5, pulse step -> one cpu_en pulse, pc=6, state=HALT; run_req toggled 0 -> 1 from pc=5 resumes past 5 without re-breaking.
- SLOW_DIV=4, run_req=1, slow_mode=1 -> cpu_en pulses every 4th cycle; switching slow_mode to 0 mid-count -> RUN with continuous cpu_en next cycle.
- HALT with run_req rising in the same cycle as step_pulse -> RUN entered, no extra step; reset asserted in RUN -> cpu_en=0 and state=HALT on the next edge.
